// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states,
// legal parameter ranges and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int CLK_DIV_MIN   = 1;
  localparam int CLK_DIV_MAX   = 65535;
  localparam int OVS_MIN       = 4;
  localparam int OVS_MAX       = 16;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clk pulse every CLK_DIV clks,
// phase restarted by clr so the first tick lands a full period after it.
module uart_baud_tick import uart_pkg::*; #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = cnt_w(CLK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: start-bit qualification at half a bit,
// mid-bit data/parity/stop sampling, frame/parity error and break handling.
module uart_rx_ovs import uart_pkg::*; #(
  parameter int CLK_DIV    = 4,
  parameter int OVS        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] dout,
  output logic                 en,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_clk_div
    $error("uart_rx_ovs: CLK_DIV out of range");
  end
  if (OVS < OVS_MIN || OVS > OVS_MAX || (OVS % 2) != 0) begin : g_bad_ovs
    $error("uart_rx_ovs: OVS must be even and within range");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_ovs: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_rx_ovs: STOP_BITS out of range");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_rx_ovs: PARITY_EN/PARITY_ODD must be 0 or 1");
  end

  localparam int            BW        = $clog2(DATA_BITS + 1);
  localparam int            TW        = cnt_w(OVS);
  localparam logic [TW-1:0] HALF      = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL      = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  rx_state_t            state, state_n;
  logic                 sync0, sync1, rxs;
  logic                 tick, clr, samp, fin, bad_stop;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, ferr_acc;

  // Synchronizer idles high so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= rx_data;
      sync1 <= sync0;
    end
  end
  assign rxs = sync1;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clr      = 1'b0;
    fin      = 1'b0;
    samp     = tick && (tcnt == ((state == START) ? HALF : FULL));
    bad_stop = ferr_acc | ~rxs;
    case (state)
      IDLE:   if (!rxs) begin
                state_n = START;
                clr     = 1'b1;
              end
      START:  if (samp) state_n = rxs ? IDLE : DATA;
      DATA:   if (samp && bcnt == LAST_DATA) state_n = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (samp) state_n = STOP;
      STOP:   if (samp && bcnt == LAST_STOP) begin
                fin     = 1'b1;
                // All-zero word with a low stop and a still-low line is a break.
                state_n = (bad_stop && shreg == '0 && !rxs) ? BREAK : IDLE;
              end
      BREAK:  if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
      dout       <= '0;
      en         <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      en <= fin;
      if (state_n != state || samp) tcnt <= '0;
      else if (tick)                tcnt <= tcnt + 1'b1;
      if (state_n != state) bcnt <= '0;
      else if (samp)        bcnt <= bcnt + 1'b1;
      if (state == IDLE)           ferr_acc <= 1'b0;
      if (samp && state == DATA)   shreg    <= {rxs, shreg[DATA_BITS-1:1]};
      if (samp && state == PARITY) par_bit  <= rxs;
      if (samp && state == STOP)   ferr_acc <= bad_stop;
      if (fin) begin
        dout       <= shreg;
        frame_err  <= bad_stop;
        parity_err <= (PARITY_EN != 0) ? (par_bit ^ (^shreg) ^ ODD) : 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per oversample tick (1..65535).
REQ-002 SHALL have parameter OVS, default 16: ticks per bit (even, 4..16).
REQ-003 SHALL have parameter DATA_BITS, default 8: payload width (5..9).
REQ-004 SHALL have parameter PARITY_EN, default 0: 1 = parity bit present.
REQ-005 SHALL have parameter PARITY_ODD, default 0: 1 = odd parity, 0 = even.
REQ-006 SHALL have parameter STOP_BITS, default 1: stop bits checked (1 or 2).
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port rx_data  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port dout  output  DATA_BITS  last received word, LSB = first data bit.
REQ-011 SHALL have port en  output  1  one-cycle strobe, dout/errors valid.
REQ-012 SHALL have port parity_err  output  1  parity mismatch on current word.
REQ-013 SHALL have port frame_err  output  1  stop bit sampled low on current word.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL pass rx_data through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 SHALL produce a one-clk tick every CLK_DIV clks, free-running; tick counter restarts at 0 on entry to START.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-018 IDLE -> START on synchronized low; tick-in-bit counter cleared.
REQ-019 START: at OVS/2 ticks, sample; low -> DATA (counter reset), high -> IDLE (false start, no en).
REQ-020 DATA: sample every OVS ticks (mid-bit), shift LSB first; after DATA_BITS samples -> PARITY if PARITY_EN else STOP.
REQ-021 PARITY: sample after OVS ticks; parity_err = sampled bit XOR (XOR of data) XOR PARITY_ODD.
REQ-022 STOP: sample each stop bit after OVS ticks; any low stop sample sets frame_err.
REQ-023 After final stop sample: dout, parity_err, frame_err update and en = 1 for exactly one clk, same edge.
REQ-024 After final stop: -> IDLE if line high; if frame_err and all data bits zero and line low -> BREAK.
REQ-025 BREAK: hold until synchronized line high, then -> IDLE; no further en.
REQ-026 dout, parity_err, frame_err SHALL hold between en strobes.
REQ-027 A new start bit SHALL be accepted on the first synchronized low after returning to IDLE (back-to-back frames, no idle gap required).
REQ-028 Latency: en asserts within one tick of the mid-point of the final stop bit.
REQ-029 Bit counter SHALL be ceil(log2(DATA_BITS+1)) wide; tick counters sized from CLK_DIV and OVS.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, all counters 0, shift register 0.
REQ-031 During reset: dout = 0, en = 0, parity_err = 0, frame_err = 0, busy = 0; synchronizer flops = 1.
REQ-032 Reset mid-frame SHALL discard the partial word; no en on release.

Structure
REQ-033 State encoding enum and parameter legal-range constants SHALL live in shared package uart_pkg.
REQ-034 Tick generator SHALL be sub-module uart_baud_tick (parameter CLK_DIV; ports clk, rst, clr, tick).
REQ-035 Parameter values outside legal ranges SHALL trigger an elaboration-time error.

Verification
REQ-036 Defaults, send 0xA5 8N1 at CLK_DIV*OVS clks/bit -> en once, dout = 0xA5, both errors 0.
REQ-037 PARITY_EN=1, PARITY_ODD=0, send 0x3C with parity bit 1 -> dout = 0x3C, parity_err = 1.
REQ-038 Low glitch of 3 ticks on idle line -> no en, busy returns low by tick OVS/2+1.
REQ-039 Send 0x55 with stop bit low, then release -> en, dout = 0x55, frame_err = 1, next frame 0x12 -> frame_err = 0.
REQ-040 Line held low 30 bit times -> one en with dout = 0x00, frame_err = 1, BREAK until line high, then 0x7E received correctly.
REQ-041 Assert rst during bit 4 of 0xF0 -> all outputs 0 immediately, no en; following 0x81 received with dout = 0x81.
